// File: rtl/mips_pkg.sv
// Shared encodings for the decode stage: opcodes, function codes, ALU commands,
// FSM state codes and the registered control bundle type.
package mips_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_SLTI  = 4'd3;
    localparam logic [3:0] OP_LW    = 4'd4;
    localparam logic [3:0] OP_SW    = 4'd5;
    localparam logic [3:0] OP_BEQ   = 4'd6;
    localparam logic [3:0] OP_J     = 4'd7;
    localparam logic [3:0] OP_JAL   = 4'd8;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_SLL = 3'd2;
    localparam logic [2:0] FN_SLT = 3'd3;
    localparam logic [2:0] FN_SRL = 3'd4;
    localparam logic [2:0] FN_AND = 3'd5;
    localparam logic [2:0] FN_OR  = 3'd6;
    localparam logic [2:0] FN_JR  = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_CMP = 3'b111;

    typedef logic [1:0] state_t;
    localparam state_t ST_BOOT    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_BR_WAIT = 2'd2;
    localparam state_t ST_SQUASH  = 2'd3;

    typedef struct packed {
        logic [2:0] alu_cmd;
        logic       op2_sel;
        logic       shamt_imm_sel;
        logic       res_sel;
        logic       wb_sel;
        logic       jump_sel;
        logic       beq_sel;
        logic       ram_rd;
        logic       ram_wr;
        logic       wb_wr;
        logic [2:0] wb_waddr;
        logic [2:0] rs_addr;
        logic [2:0] rt_addr;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        alu_cmd: ALU_ADD, op2_sel: 1'b0, shamt_imm_sel: 1'b0, res_sel: 1'b1,
        wb_sel: 1'b0, jump_sel: 1'b0, beq_sel: 1'b1, ram_rd: 1'b0, ram_wr: 1'b0,
        wb_wr: 1'b0, wb_waddr: 3'd0, rs_addr: 3'd0, rt_addr: 3'd0
    };

    function automatic logic reads_rt(input logic [3:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/pipe_decode_ctrl_if.sv
// Fetch/execute handshake and control-bundle signals of the decode stage.
interface pipe_decode_ctrl_if;

    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ex_ready;
    logic        br_valid;
    logic        br_taken;
    logic        ctrl_valid;
    logic [2:0]  alu_cmd;
    logic        op2_sel;
    logic        shamt_imm_sel;
    logic        res_sel;
    logic        wb_sel;
    logic        jump_sel;
    logic        beq_sel;
    logic        ram_rd;
    logic        ram_wr;
    logic        wb_wr;
    logic [2:0]  wb_waddr;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic        silence;
    logic        illegal;

    modport master (
        output instr, instr_valid, ex_ready, br_valid, br_taken,
        input  instr_ready, ctrl_valid, alu_cmd, op2_sel, shamt_imm_sel, res_sel,
               wb_sel, jump_sel, beq_sel, ram_rd, ram_wr, wb_wr, wb_waddr,
               rs_addr, rt_addr, silence, illegal
    );

    modport slave (
        input  instr, instr_valid, ex_ready, br_valid, br_taken,
        output instr_ready, ctrl_valid, alu_cmd, op2_sel, shamt_imm_sel, res_sel,
               wb_sel, jump_sel, beq_sel, ram_rd, ram_wr, wb_wr, wb_waddr,
               rs_addr, rt_addr, silence, illegal
    );

endinterface

// File: rtl/pipe_decode_ctrl_instr_decoder.sv
// Combinational instruction decoder: 16-bit instruction to control bundle,
// flagging undefined opcodes.
module instr_decoder
    import mips_pkg::*;
#(
    parameter logic [2:0] RA_REG = 3'd7
) (
    input  logic [15:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [3:0] opcode;
    logic [2:0] rs, rt, rd, fcode;

    assign {opcode, rs, rt, rd, fcode} = instr;

    always_comb begin
        ctrl         = CTRL_DEFAULT;
        ctrl.rs_addr = rs;
        ctrl.rt_addr = rt;
        illegal      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.wb_waddr = rd;
                ctrl.wb_wr    = 1'b1;
                case (fcode)
                    FN_ADD: ctrl.alu_cmd = ALU_ADD;
                    FN_SUB: ctrl.alu_cmd = ALU_SUB;
                    FN_AND: ctrl.alu_cmd = ALU_AND;
                    FN_OR:  ctrl.alu_cmd = ALU_OR;
                    FN_SLT: ctrl.alu_cmd = ALU_SLT;
                    FN_SLL: begin
                        ctrl.alu_cmd       = ALU_SLL;
                        ctrl.op2_sel       = 1'b1;
                        ctrl.shamt_imm_sel = 1'b1;
                    end
                    FN_SRL: begin
                        ctrl.alu_cmd       = ALU_SRL;
                        ctrl.op2_sel       = 1'b1;
                        ctrl.shamt_imm_sel = 1'b1;
                    end
                    FN_JR: begin
                        ctrl.alu_cmd  = ALU_ADD;
                        ctrl.jump_sel = 1'b1;
                        ctrl.wb_wr    = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                ctrl.op2_sel  = 1'b1;
                ctrl.wb_wr    = 1'b1;
                ctrl.wb_waddr = rt;
            end
            OP_SLTI: begin
                ctrl.op2_sel  = 1'b1;
                ctrl.wb_wr    = 1'b1;
                ctrl.wb_waddr = rt;
                ctrl.alu_cmd  = ALU_SLT;
            end
            OP_LW: begin
                ctrl.op2_sel  = 1'b1;
                ctrl.ram_rd   = 1'b1;
                ctrl.res_sel  = 1'b0;
                ctrl.wb_wr    = 1'b1;
                ctrl.wb_waddr = rt;
            end
            OP_SW: begin
                ctrl.op2_sel = 1'b1;
                ctrl.ram_wr  = 1'b1;
            end
            OP_BEQ: begin
                ctrl.beq_sel = 1'b0;
                ctrl.alu_cmd = ALU_CMP;
            end
            OP_J: begin
                ctrl.op2_sel  = 1'b1;
                ctrl.jump_sel = 1'b1;
            end
            OP_JAL: begin
                ctrl.op2_sel  = 1'b1;
                ctrl.jump_sel = 1'b1;
                ctrl.wb_sel   = 1'b1;
                ctrl.wb_wr    = 1'b1;
                ctrl.wb_waddr = RA_REG;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// Decode-stage controller: issue FSM, post-jump/branch squash and optional
// load-use interlock (enabled by defining LOAD_USE_STALL_EN).
module pipe_decode_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 3,
    parameter logic [2:0]  RA_REG      = 3'd7
) (
    input  logic             clk,
    input  logic             rst,
    pipe_decode_ctrl_if.slave bus
);

    state_t     state_q;
    logic [2:0] cnt_q;
    logic       br_pend_q, br_taken_q;
    ctrl_t      bundle_q, dec;
    logic       valid_q, illegal_q;
    logic       dec_illegal, hazard, accept, issue, advance;

    instr_decoder #(.RA_REG(RA_REG)) u_decoder (
        .instr   (bus.instr),
        .ctrl    (dec),
        .illegal (dec_illegal)
    );

    assign bus.instr_ready = ((state_q == ST_RUN) && bus.ex_ready && !hazard)
                           || (state_q == ST_SQUASH);
    assign accept  = bus.instr_valid && bus.instr_ready;
    assign issue   = accept && (state_q == ST_RUN) && !dec_illegal;
    assign advance = bus.ex_ready && (state_q != ST_BOOT);

`ifdef LOAD_USE_STALL_EN
    logic       lw_q;
    logic [2:0] lw_dst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lw_q     <= 1'b0;
            lw_dst_q <= '0;
        end else if (advance) begin
            lw_q     <= issue && dec.ram_rd;
            lw_dst_q <= dec.wb_waddr;
        end
    end

    assign hazard = lw_q && ((lw_dst_q == bus.instr[11:9])
                  || (reads_rt(bus.instr[15:12]) && (lw_dst_q == bus.instr[8:6])));
`else
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            cnt_q      <= '0;
            br_pend_q  <= 1'b0;
            br_taken_q <= 1'b0;
            bundle_q   <= '0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q <= accept && (state_q == ST_RUN) && dec_illegal;
            if (advance) begin
                bundle_q <= issue ? dec : CTRL_DEFAULT;
                valid_q  <= issue;
            end
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (issue && dec.jump_sel) begin
                        state_q <= ST_SQUASH;
                        cnt_q   <= 3'(FLUSH_DEPTH);
                    end else if (issue && !dec.beq_sel) begin
                        // a resolution arriving with the beq itself is kept for BR_WAIT
                        state_q    <= ST_BR_WAIT;
                        br_pend_q  <= bus.br_valid;
                        br_taken_q <= bus.br_taken;
                    end
                end
                ST_BR_WAIT: begin
                    if (bus.br_valid || br_pend_q) begin
                        br_pend_q <= 1'b0;
                        // with a one-deep flush the taken branch leaves nothing to squash
                        if ((bus.br_valid ? bus.br_taken : br_taken_q) && (FLUSH_DEPTH > 1)) begin
                            state_q <= ST_SQUASH;
                            cnt_q   <= 3'(FLUSH_DEPTH - 1);
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_SQUASH: begin
                    if (accept) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q <= 3'd1) state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign bus.silence       = (state_q == ST_SQUASH);
    assign bus.illegal       = illegal_q;
    assign bus.ctrl_valid    = valid_q;
    assign bus.alu_cmd       = bundle_q.alu_cmd;
    assign bus.op2_sel       = bundle_q.op2_sel;
    assign bus.shamt_imm_sel = bundle_q.shamt_imm_sel;
    assign bus.res_sel       = bundle_q.res_sel;
    assign bus.wb_sel        = bundle_q.wb_sel;
    assign bus.jump_sel      = bundle_q.jump_sel;
    assign bus.beq_sel       = bundle_q.beq_sel;
    assign bus.ram_rd        = bundle_q.ram_rd;
    assign bus.ram_wr        = bundle_q.ram_wr;
    assign bus.wb_wr         = bundle_q.wb_wr;
    assign bus.wb_waddr      = bundle_q.wb_waddr;
    assign bus.rs_addr       = bundle_q.rs_addr;
    assign bus.rt_addr       = bundle_q.rt_addr;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl; expected values are hand-computed
// for FLUSH_DEPTH=3, RA_REG=7, with or without LOAD_USE_STALL_EN.
module tb_pipe_decode_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_decode_ctrl_if bus ();

    pipe_decode_ctrl #(.FLUSH_DEPTH(3), .RA_REG(3'd7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.instr = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.ex_ready = 1'b1;
        bus.br_valid = 1'b0;
        bus.br_taken = 1'b0;
        #1;
        chk("rst_valid", 16'(bus.ctrl_valid), 16'h0);
        chk("rst_res_sel", 16'(bus.res_sel), 16'h0);
        chk("rst_beq_sel", 16'(bus.beq_sel), 16'h0);
        chk("rst_ready", 16'(bus.instr_ready), 16'h0);
        chk("rst_silence", 16'(bus.silence), 16'h0);
        chk("rst_illegal", 16'(bus.illegal), 16'h0);

        tick(); rst = 1'b1; #1;
        chk("boot_ready", 16'(bus.instr_ready), 16'h0);
        tick();
        chk("run_ready", 16'(bus.instr_ready), 16'h1);
        chk("boot_no_issue", 16'(bus.res_sel), 16'h0);
        tick();
        chk("bubble_valid", 16'(bus.ctrl_valid), 16'h0);
        chk("bubble_res_sel", 16'(bus.res_sel), 16'h1);
        chk("bubble_beq_sel", 16'(bus.beq_sel), 16'h1);

        // add r3 = r1 + r2
        bus.instr = 16'h0298; bus.instr_valid = 1'b1;
        tick(); bus.instr_valid = 1'b0;
        chk("add_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("add_alu", 16'(bus.alu_cmd), 16'h0);
        chk("add_waddr", 16'(bus.wb_waddr), 16'h3);
        chk("add_wr", 16'(bus.wb_wr), 16'h1);
        chk("add_rs", 16'(bus.rs_addr), 16'h1);
        chk("add_rt", 16'(bus.rt_addr), 16'h2);
        chk("add_op2", 16'(bus.op2_sel), 16'h0);

        // ex_ready low: bundle holds and nothing is accepted
        bus.ex_ready = 1'b0; bus.instr = 16'h1305; bus.instr_valid = 1'b1; #1;
        chk("stall_ready", 16'(bus.instr_ready), 16'h0);
        tick();
        chk("hold_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("hold_waddr", 16'(bus.wb_waddr), 16'h3);
        bus.ex_ready = 1'b1;
        tick();
        chk("addi_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("addi_op2", 16'(bus.op2_sel), 16'h1);
        chk("addi_waddr", 16'(bus.wb_waddr), 16'h4);
        chk("addi_wr", 16'(bus.wb_wr), 16'h1);

        bus.instr = 16'h006A;
        tick();
        chk("sll_alu", 16'(bus.alu_cmd), 16'h2);
        chk("sll_shamt", 16'(bus.shamt_imm_sel), 16'h1);
        chk("sll_waddr", 16'(bus.wb_waddr), 16'h5);

        bus.instr = 16'h5283;
        tick();
        chk("sw_ram_wr", 16'(bus.ram_wr), 16'h1);
        chk("sw_wb_wr", 16'(bus.wb_wr), 16'h0);
        chk("sw_op2", 16'(bus.op2_sel), 16'h1);

        // lw r2, then add using rs=2
        bus.instr = 16'h4680;
        tick();
        chk("lw_ram_rd", 16'(bus.ram_rd), 16'h1);
        chk("lw_res_sel", 16'(bus.res_sel), 16'h0);
        chk("lw_waddr", 16'(bus.wb_waddr), 16'h2);
        bus.instr = 16'h0458; #1;
`ifdef LOAD_USE_STALL_EN
        chk("lu_ready", 16'(bus.instr_ready), 16'h0);
        tick();
        chk("lu_bubble", 16'(bus.ctrl_valid), 16'h0);
        chk("lu_bubble_wr", 16'(bus.wb_wr), 16'h0);
        tick();
`else
        chk("lu_ready", 16'(bus.instr_ready), 16'h1);
        tick();
`endif
        bus.instr_valid = 1'b0;
        chk("lu_add_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("lu_add_rs", 16'(bus.rs_addr), 16'h2);
        chk("lu_add_waddr", 16'(bus.wb_waddr), 16'h3);

        bus.instr = 16'hF000; bus.instr_valid = 1'b1;
        tick(); bus.instr_valid = 1'b0;
        chk("ill_pulse", 16'(bus.illegal), 16'h1);
        chk("ill_valid", 16'(bus.ctrl_valid), 16'h0);
        tick();
        chk("ill_end", 16'(bus.illegal), 16'h0);

        // j: three discarded instructions under silence, then RUN
        bus.instr = 16'h7005; bus.instr_valid = 1'b1;
        tick();
        chk("j_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("j_jump", 16'(bus.jump_sel), 16'h1);
        chk("j_silence", 16'(bus.silence), 16'h1);
        chk("j_ready", 16'(bus.instr_ready), 16'h1);
        bus.instr = 16'h0298;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sq_valid", 16'(bus.ctrl_valid), 16'h0);
            chk("sq_jump", 16'(bus.jump_sel), 16'h0);
            chk("sq_silence", 16'(bus.silence), (i < 2) ? 16'h1 : 16'h0);
        end
        tick();
        chk("post_j_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("post_j_waddr", 16'(bus.wb_waddr), 16'h3);

        bus.instr = 16'h8000;
        tick();
        chk("jal_jump", 16'(bus.jump_sel), 16'h1);
        chk("jal_wb_sel", 16'(bus.wb_sel), 16'h1);
        chk("jal_wr", 16'(bus.wb_wr), 16'h1);
        chk("jal_waddr", 16'(bus.wb_waddr), 16'h7);
        bus.instr = 16'h0298;
        tick(); tick(); tick();
        chk("jal_sq_end", 16'(bus.silence), 16'h0);
        bus.instr_valid = 1'b0;

        // beq not taken, resolved three cycles later
        bus.instr = 16'h6280; bus.instr_valid = 1'b1;
        tick();
        bus.instr = 16'h0298;
        chk("beq_valid", 16'(bus.ctrl_valid), 16'h1);
        chk("beq_sel", 16'(bus.beq_sel), 16'h0);
        chk("beq_alu", 16'(bus.alu_cmd), 16'h7);
        chk("beq_ready", 16'(bus.instr_ready), 16'h0);
        tick(); tick();
        chk("bw_valid", 16'(bus.ctrl_valid), 16'h0);
        chk("bw_ready", 16'(bus.instr_ready), 16'h0);
        bus.br_valid = 1'b1; bus.br_taken = 1'b0;
        tick(); bus.br_valid = 1'b0;
        chk("nt_silence", 16'(bus.silence), 16'h0);
        chk("nt_ready", 16'(bus.instr_ready), 16'h1);
        tick();
        chk("nt_next_valid", 16'(bus.ctrl_valid), 16'h1);
        bus.instr_valid = 1'b0;

        // beq taken: squash FLUSH_DEPTH-1 instructions
        bus.instr = 16'h6280; bus.instr_valid = 1'b1;
        tick();
        bus.instr = 16'h0298; bus.br_valid = 1'b1; bus.br_taken = 1'b1;
        tick(); bus.br_valid = 1'b0; bus.br_taken = 1'b0;
        chk("tk_silence", 16'(bus.silence), 16'h1);
        tick();
        chk("tk_sq1", 16'(bus.silence), 16'h1);
        chk("tk_sq1_valid", 16'(bus.ctrl_valid), 16'h0);
        tick();
        chk("tk_sq2", 16'(bus.silence), 16'h0);
        chk("tk_sq2_valid", 16'(bus.ctrl_valid), 16'h0);
        bus.instr_valid = 1'b0;

        // resolution arriving in the same cycle the beq is accepted
        bus.instr = 16'h6280; bus.instr_valid = 1'b1; bus.br_valid = 1'b1; bus.br_taken = 1'b0;
        tick(); bus.instr_valid = 1'b0; bus.br_valid = 1'b0;
        chk("early_wait", 16'(bus.instr_ready), 16'h0);
        tick();
        chk("early_run", 16'(bus.instr_ready), 16'h1);
        chk("early_silence", 16'(bus.silence), 16'h0);

        // asynchronous reset in the middle of a squash
        bus.instr = 16'h7005; bus.instr_valid = 1'b1;
        tick(); bus.instr_valid = 1'b0;
        chk("pre_rst_silence", 16'(bus.silence), 16'h1);
        #2 rst = 1'b0; #1;
        chk("arst_silence", 16'(bus.silence), 16'h0);
        chk("arst_valid", 16'(bus.ctrl_valid), 16'h0);
        chk("arst_jump", 16'(bus.jump_sel), 16'h0);
        chk("arst_res_sel", 16'(bus.res_sel), 16'h0);
        chk("arst_ready", 16'(bus.instr_ready), 16'h0);
        tick(); rst = 1'b1; #1;
        chk("reboot_ready", 16'(bus.instr_ready), 16'h0);
        tick();
        chk("rerun_ready", 16'(bus.instr_ready), 16'h1);
        chk("rerun_silence", 16'(bus.silence), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
